array_div4: RTL and testbench

Sequential restoring divider; the inverse of the team's 4x4 array multiplier. It divides an 8-bit dividend by a 4-bit divisor and produces a 4-bit quotient and 4-bit remainder, so that dividend = quotient*divisor + remainder. The datapath computes one quotient bit per clock. A start/busy/done handshake sits in front of it, and the block reports divide-by-zero and quotient overflow. It is the divide unit next to the multiplier in the arithmetic datapath.

---
 rtl/array_div4_if.sv | 27 ++
 rtl/array_div4.sv | 124 ++++++++++++
 tb/tb_array_div4.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/array_div4_if.sv
// Divider request/result bundle: start + operands in, status + results out.
// Latency: n/a (wiring only).
// Backpressure: start is only taken while ready is high; no queuing.
interface array_div4_if #(
    parameter int W = 4
);
    logic               start;
    logic [2*W-1:0]     dividend;
    logic [W-1:0]       divisor;
    logic               ready;
    logic               busy;
    logic               done;
    logic [W-1:0]       quotient;
    logic [W-1:0]       remainder;
    logic               div_by_zero;
    logic               overflow;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/array_div4.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Latency: W+1 edges from accept to done on the normal path, 1 edge on zero/overflow.
// Backpressure: start is ignored unless ready; one division in flight, results held until the next one ends.
module array_div4 #(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst,
    array_div4_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W:0]      r;      // partial remainder, always < divisor between steps
    logic [W-1:0]    q;      // low dividend bits shifting out, quotient bits shifting in
    logic [W-1:0]    dvs;    // captured divisor
    logic [CW-1:0]   cnt;

    // One restoring step: shift {R,Q} left, trial-subtract, keep or restore.
    logic [W+1:0]    r_sh;
    logic [W+1:0]    t;
    logic            borrow;
    logic [W:0]      r_nx;
    logic [W-1:0]    q_nx;
    logic [W-1:0]    upper;
    logic [W-1:0]    lower;
    logic            ovf_in;

    // Next partial remainder/quotient for the current step, plus entry overflow test.
    always_comb begin
        r_sh   = {r, q[W-1]};
        t      = r_sh - {2'b00, dvs};
        borrow = t[W+1];
        r_nx   = borrow ? r_sh[W:0] : t[W:0];
        q_nx   = {q[W-2:0], ~borrow};
        upper  = bus.dividend[2*W-1:W];
        lower  = bus.dividend[W-1:0];
        ovf_in = (upper >= bus.divisor);
    end

    // Control FSM, datapath registers and result/status outputs, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            r               <= '0;
            q               <= '0;
            dvs             <= '0;
            cnt             <= '0;
            bus.ready       <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvs <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.ready       <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.div_by_zero <= 1'b1;
                            bus.overflow    <= 1'b0;
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                        end else if (ovf_in) begin
                            state           <= DONE;
                            bus.ready       <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                        end else begin
                            // Upper half < divisor, so R starts below the divisor
                            // and every shifted R fits in W+1 bits.
                            r         <= {1'b0, upper};
                            q         <= lower;
                            cnt       <= CW'(W - 1);
                            state     <= CALC;
                            bus.ready <= 1'b0;
                            bus.busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // Results and flags only move on the edge that enters DONE.
                        bus.quotient    <= q_nx;
                        bus.remainder   <= r_nx[W-1:0];
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_array_div4.sv
// Bench for array_div4: directed cases, random back-to-back starts, mid-run reset, exhaustive sweep.
// Expected results come from integer division in a reference function.
// Every DUT wait is bounded by a cycle budget.
module tb_array_div4;
    localparam int W    = 4;
    localparam int QMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;

    array_div4_if #(.W(W)) bus ();

    array_div4 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the error cases folded in.
    function automatic void ref_div(input int dd, input int dv,
                                    output int q, output int r, output int dz, output int ov);
        dz = 0; ov = 0;
        if (dv == 0) begin
            dz = 1; q = QMAX; r = 0;
        end else if (dd / dv > QMAX) begin
            ov = 1; q = QMAX; r = 0;
        end else begin
            q = dd / dv; r = dd % dv;
        end
    endfunction

    task automatic check_results(input string tag, input int dd, input int dv);
        int eq, er, edz, eov;
        ref_div(dd, dv, eq, er, edz, eov);
        check({tag, " quotient"},    32'(bus.quotient),    eq);
        check({tag, " remainder"},   32'(bus.remainder),   er);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), edz);
        check({tag, " overflow"},    32'(bus.overflow),    eov);
        if (edz == 0 && eov == 0) begin
            check({tag, " q*d+r"},  32'(bus.quotient) * dv + 32'(bus.remainder), dd);
            check({tag, " r<d"},    32'(bus.remainder < dv[W-1:0]), 1);
        end else begin
            check({tag, " one flag"}, 32'(bus.div_by_zero) + 32'(bus.overflow), 1);
        end
    endtask

    // One complete division; called and returns at posedge+1.
    task automatic run_op(input int dd, input int dv, input string tag);
        int cyc, bsy, eq, er, edz, eov, lat;
        cyc = 0;
        while (!bus.ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, " ready before start"}, 32'(bus.ready), 1);
        bus.start    = 1'b1;
        bus.dividend = dd[2*W-1:0];
        bus.divisor  = dv[W-1:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0; bsy = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) bsy++;
            check({tag, " onehot"}, $countones({bus.ready, bus.busy, bus.done}), 1);
            @(posedge clk); #1; cyc++;
        end
        ref_div(dd, dv, eq, er, edz, eov);
        lat = (edz != 0 || eov != 0) ? 0 : W;
        check({tag, " done latency"}, cyc, lat);
        check({tag, " busy cycles"},  bsy, lat);
        check({tag, " onehot at done"}, $countones({bus.ready, bus.busy, bus.done}), 1);
        check_results(tag, dd, dv);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 32'(bus.done),  0);
        check({tag, " ready again"},    32'(bus.ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " ready"},       32'(bus.ready),       1);
        check({tag, " busy"},        32'(bus.busy),        0);
        check({tag, " done"},        32'(bus.done),        0);
        check({tag, " quotient"},    32'(bus.quotient),    0);
        check({tag, " remainder"},   32'(bus.remainder),   0);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 0);
        check({tag, " overflow"},    32'(bus.overflow),    0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int qdd[$];
        int qdv[$];
        int nd, nv, cyc;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check_reset_values("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("after reset");

        // Directed cases
        run_op(100, 7,  "100/7");
        run_op(224, 15, "224/15");
        run_op(0,   5,  "0/5");
        run_op(42,  0,  "42/0");
        run_op(255, 15, "255/15");
        run_op(16,  1,  "16/1");
        run_op(15,  1,  "15/1");

        // Random single operations
        for (int i = 0; i < 30; i++) begin
            nd = int'($urandom_range(0, 255));
            nv = int'($urandom_range(0, 15));
            run_op(nd, nv, "random");
        end

        // start held high; operands change every cycle
        bus.start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                check("stream done has pending op", 32'(qdd.size() > 0), 1);
                if (qdd.size() > 0) begin
                    nd = qdd.pop_front();
                    nv = qdv.pop_front();
                    check_results("stream", nd, nv);
                end
            end
            nd = int'($urandom_range(0, 255));
            nv = int'($urandom_range(0, 15));
            if (i % 3 == 0) nd = int'($urandom_range(0, 255)) % (nv * 16 + 1);
            bus.dividend = nd[2*W-1:0];
            bus.divisor  = nv[W-1:0];
            if (bus.ready) begin
                qdd.push_back(nd);
                qdv.push_back(nv);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        cyc = 0;
        while (qdd.size() > 0 && cyc < 20) begin
            if (bus.done) begin
                nd = qdd.pop_front();
                nv = qdv.pop_front();
                check_results("stream drain", nd, nv);
            end
            @(posedge clk); #1; cyc++;
        end
        check("stream all completed", qdd.size(), 0);
        cyc = 0;
        while (!bus.ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end

        // Reset two cycles into CALC
        run_op(100, 7, "pre-abort");
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort busy before rst", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check_reset_values("abort async");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort no done", 32'(bus.done), 0);
            @(posedge clk); #1;
        end
        run_op(100, 7, "post-abort");

        // Exhaustive sweep
        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                run_op(dd, dv, "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
